// File: rtl/gate_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : gate_mux_if
//  Description : Operand/select/result bundle for gate_mux.
//                master : drives a, b, sel; receives y
//                slave  : receives a, b, sel; drives y
//                With GATE_MUX_VALID_EN defined the bundle also carries
//                in_valid (master -> slave) and out_valid (slave -> master).
//  Revision    : 1.0  initial release
// ============================================================================
interface gate_mux_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;
`ifdef GATE_MUX_VALID_EN
  logic             in_valid;
  logic             out_valid;

  modport master (output a, b, sel, in_valid, input y, out_valid);
  modport slave  (input a, b, sel, in_valid, output y, out_valid);
`else
  modport master (output a, b, sel, input y);
  modport slave  (input a, b, sel, output y);
`endif
endinterface
`default_nettype wire

// File: rtl/gate_mux.sv
`default_nettype none
// ============================================================================
//  Module      : gate_mux
//  Description : Selectable bitwise two-input gate (AND/OR/XOR/NAND) built
//                only from 2:1 mux cells, with a registered result.
//                Ports : clk  - system clock (rising edge)
//                        rst  - synchronous active-high reset, y -> 0
//                        bus  - gate_mux_if.slave: a, b, sel in; y out
//                sel : 00 AND, 01 OR, 10 XOR, 11 NAND. Latency 1 cycle.
//                Optional macro GATE_MUX_VALID_EN: y loads only when
//                in_valid=1; out_valid is in_valid delayed one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module gate_mux #(
  parameter int WIDTH = 1
) (
  input  wire logic   clk,
  input  wire logic   rst,
  gate_mux_if.slave   bus
);

  // The only logic primitive used in the datapath.
  function automatic logic mux2(input logic s, input logic d0, input logic d1);
    return s ? d1 : d0;
  endfunction

  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_and;
    logic w_or;
    logic w_not_b;
    logic w_xor;
    logic w_nand;
    logic w_lvl1_lo;
    logic w_lvl1_hi;

    // Each gate uses operand a as the mux select, so the gate output is
    // either a constant or b / NOT b depending on a.
    assign w_and     = mux2(bus.a[i], 1'b0,       bus.b[i]);
    assign w_or      = mux2(bus.a[i], bus.b[i],   1'b1);
    assign w_not_b   = mux2(bus.b[i], 1'b1,       1'b0);
    assign w_xor     = mux2(bus.a[i], bus.b[i],   w_not_b);
    assign w_nand    = mux2(bus.a[i], 1'b1,       w_not_b);

    // Two-level selection tree: sel[0] pairs AND/OR and XOR/NAND,
    // sel[1] picks between the pairs.
    assign w_lvl1_lo = mux2(bus.sel[0], w_and, w_or);
    assign w_lvl1_hi = mux2(bus.sel[0], w_xor, w_nand);
    assign w_res[i]  = mux2(bus.sel[1], w_lvl1_lo, w_lvl1_hi);
  end : g_bit

`ifdef GATE_MUX_VALID_EN
  logic out_valid_d;
  logic out_valid_q;

  always_comb begin
    y_d         = y_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      y_d = w_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
`else
  always_comb begin
    y_d = w_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end
`endif

  assign bus.y = y_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_mux
//  Description : Directed, table-driven bench for gate_mux. Drives a 1-bit
//                and a 4-bit instance from a common clock and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gate_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_mux_if #(.WIDTH(1)) bus1 ();
  gate_mux_if #(.WIDTH(4)) bus4 ();

  gate_mux #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  gate_mux #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       a;
    logic       b;
    logic [1:0] sel;
    logic       y;
  } vec1_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic [3:0] y;
  } vec4_t;

  vec1_t tt[16];
  vec4_t tv[8];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic a, input logic b, input logic [1:0] sel);
    bus1.a   = a;
    bus1.b   = b;
    bus1.sel = sel;
  endtask

  initial begin
    // Exhaustive truth table, hand-computed: AND, OR, XOR, NAND.
    tt[0]  = '{1'b0, 1'b0, 2'b00, 1'b0};
    tt[1]  = '{1'b0, 1'b0, 2'b01, 1'b0};
    tt[2]  = '{1'b0, 1'b0, 2'b10, 1'b0};
    tt[3]  = '{1'b0, 1'b0, 2'b11, 1'b1};
    tt[4]  = '{1'b0, 1'b1, 2'b00, 1'b0};
    tt[5]  = '{1'b0, 1'b1, 2'b01, 1'b1};
    tt[6]  = '{1'b0, 1'b1, 2'b10, 1'b1};
    tt[7]  = '{1'b0, 1'b1, 2'b11, 1'b1};
    tt[8]  = '{1'b1, 1'b0, 2'b00, 1'b0};
    tt[9]  = '{1'b1, 1'b0, 2'b01, 1'b1};
    tt[10] = '{1'b1, 1'b0, 2'b10, 1'b1};
    tt[11] = '{1'b1, 1'b0, 2'b11, 1'b1};
    tt[12] = '{1'b1, 1'b1, 2'b00, 1'b1};
    tt[13] = '{1'b1, 1'b1, 2'b01, 1'b1};
    tt[14] = '{1'b1, 1'b1, 2'b10, 1'b0};
    tt[15] = '{1'b1, 1'b1, 2'b11, 1'b0};

    tv[0] = '{4'b1100, 4'b1010, 2'b00, 4'b1000};
    tv[1] = '{4'b1100, 4'b1010, 2'b01, 4'b1110};
    tv[2] = '{4'b1100, 4'b1010, 2'b10, 4'b0110};
    tv[3] = '{4'b1100, 4'b1010, 2'b11, 4'b0111};
    tv[4] = '{4'b0000, 4'b1111, 2'b00, 4'b0000};
    tv[5] = '{4'b0000, 4'b1111, 2'b01, 4'b1111};
    tv[6] = '{4'b0101, 4'b0011, 2'b10, 4'b0110};
    tv[7] = '{4'b1111, 4'b1111, 2'b11, 4'b0000};

    rst = 1'b1;
    drive1(1'b1, 1'b1, 2'b01);
    bus4.a   = 4'b1111;
    bus4.b   = 4'b1111;
    bus4.sel = 2'b01;
`ifdef GATE_MUX_VALID_EN
    bus1.in_valid = 1'b1;
    bus4.in_valid = 1'b1;
`endif

    // Reset held two edges with inputs that would otherwise give all ones.
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("reset_y1_%0d", i), {3'b000, bus1.y}, 4'b0000);
      check($sformatf("reset_y4_%0d", i), bus4.y, 4'b0000);
`ifdef GATE_MUX_VALID_EN
      check($sformatf("reset_ov1_%0d", i), {3'b000, bus1.out_valid}, 4'b0000);
`endif
    end
    rst = 1'b0;
    tick();
    check("post_reset_y1", {3'b000, bus1.y}, 4'b0001);
    check("post_reset_y4", bus4.y, 4'b1111);

    // Function sweep a=1, b=0 with a one-cycle reset pulse in the middle.
    drive1(1'b1, 1'b0, 2'b00);
    tick();
    check("sweep_and", {3'b000, bus1.y}, 4'b0000);
    drive1(1'b1, 1'b0, 2'b01);
    tick();
    check("sweep_or", {3'b000, bus1.y}, 4'b0001);
    // Inputs changing between edges must not reach y.
    drive1(1'b0, 1'b0, 2'b00);
    #3;
    check("between_edges_hold", {3'b000, bus1.y}, 4'b0001);
    drive1(1'b1, 1'b0, 2'b10);
    rst = 1'b1;
    tick();
    check("midstream_rst", {3'b000, bus1.y}, 4'b0000);
    rst = 1'b0;
    tick();
    check("sweep_xor_after_rst", {3'b000, bus1.y}, 4'b0001);
    drive1(1'b1, 1'b0, 2'b11);
    tick();
    check("sweep_nand", {3'b000, bus1.y}, 4'b0001);

    // Exhaustive 1-bit truth table.
    for (int i = 0; i < 16; i++) begin
      drive1(tt[i].a, tt[i].b, tt[i].sel);
      tick();
      check($sformatf("tt_a%0b_b%0b_sel%02b", tt[i].a, tt[i].b, tt[i].sel),
            {3'b000, bus1.y}, {3'b000, tt[i].y});
    end

    // 4-bit vectors.
    for (int i = 0; i < 8; i++) begin
      bus4.a   = tv[i].a;
      bus4.b   = tv[i].b;
      bus4.sel = tv[i].sel;
      tick();
      check($sformatf("vec4_%0d_sel%02b", i, tv[i].sel), bus4.y, tv[i].y);
    end

`ifdef GATE_MUX_VALID_EN
    // Load 0 (1 XOR 1), then hold while inputs would give 1.
    bus1.in_valid = 1'b1;
    drive1(1'b1, 1'b1, 2'b10);
    tick();
    check("valid_load0_y", {3'b000, bus1.y}, 4'b0000);
    check("valid_load0_ov", {3'b000, bus1.out_valid}, 4'b0001);
    bus1.in_valid = 1'b0;
    drive1(1'b1, 1'b1, 2'b01);
    tick();
    check("valid_hold_y_a", {3'b000, bus1.y}, 4'b0000);
    check("valid_hold_ov_a", {3'b000, bus1.out_valid}, 4'b0000);
    drive1(1'b0, 1'b0, 2'b11);
    tick();
    check("valid_hold_y_b", {3'b000, bus1.y}, 4'b0000);
    check("valid_hold_ov_b", {3'b000, bus1.out_valid}, 4'b0000);
    bus1.in_valid = 1'b1;
    drive1(1'b1, 1'b0, 2'b10);
    tick();
    check("valid_accept_y", {3'b000, bus1.y}, 4'b0001);
    check("valid_accept_ov", {3'b000, bus1.out_valid}, 4'b0001);
    rst = 1'b1;
    tick();
    check("valid_rst_y", {3'b000, bus1.y}, 4'b0000);
    check("valid_rst_ov", {3'b000, bus1.out_valid}, 4'b0000);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_mux.md
Name: gate_mux

Overview:
Selectable two-input logic-gate unit. Each gate function is realised only from 2:1 multiplexer cells, and a 4:1 mux tree chooses the result.
- Operands a, b are bitwise WIDTH-bit vectors; 2-bit sel picks the function.
- Result is registered on clk.
- Used as a small configurable logic element and as the mux-based-logic reference block in the DSD exercise set.

Parameters:
WIDTH, 1, bit width of operands a, b and result y (bitwise operation, WIDTH >= 1)

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sel  input  2  function select
y  output  WIDTH  registered gate result

Behaviour:
- Function map, bitwise per bit i:
  - sel=00: AND, y = a & b
  - sel=01: OR, y = a | b
  - sel=10: XOR, y = a ^ b
  - sel=11: NAND, y = ~(a & b)
- Mux-only realisation, per bit, with mux2(s, d0, d1) = s ? d1 : d0:
  - AND = mux2(a, 0, b)
  - OR = mux2(a, b, 1)
  - NOT b = mux2(b, 1, 0)
  - XOR = mux2(a, b, NOT b)
  - NAND = mux2(a, 1, NOT b)
- Final selection: two-level tree of mux2 cells. Level 1 uses sel[0] to pick AND/OR and XOR/NAND. Level 2 uses sel[1].
- No behavioural operators (&, |, ^, ~, case) in the datapath; only the mux2 cell.
- Register: y updates on every rising clk edge with the function of the a, b, sel values sampled at that edge.
- Latency: exactly 1 cycle.
- Reset: rst=1 at a rising edge forces y = 0 (all WIDTH bits).
  - Reset has priority over data.
  - Deasserting rst gives a valid result on the first following edge.
- Reset mid-operation: result in flight is discarded, y=0 for each cycle rst is high.
- sel or operand changes between edges have no effect on y; only edge-sampled values matter.
- No X propagation from sel: all four codes are defined, so no illegal encodings exist.
- Power-up before first reset: y undefined. The bench must reset first.

Optional Feature:
GATE_MUX_VALID_EN
- Defined: adds input in_valid (1 bit) and output out_valid (1 bit).
  - y loads only on edges where in_valid=1; otherwise y holds its value.
  - out_valid is registered in_valid, i.e. it is 1 the cycle after an accepted input.
  - Reset clears y=0 and out_valid=0.
- Undefined: ports absent; y loads every cycle as above.

Test Plan:
- Reset: rst=1 for 2 cycles with a=1, b=1, sel=01 -> y=0 throughout; rst=0 -> y=1 after 1 edge.
- Function sweep, WIDTH=1, a=1, b=0, sel stepped 00, 01, 10, 11 one per cycle -> y = 0, 1, 1, 1, each one cycle after its sel.
- Exhaustive truth table, WIDTH=1: all 16 {a, b, sel} combinations -> y matches AND/OR/XOR/NAND table with 1-cycle lag; e.g. a=1, b=1, sel=11 -> y=0.
- Vector, WIDTH=4, a=4'b1100, b=4'b1010 -> sel=00 gives 1000, sel=01 gives 1110, sel=10 gives 0110, sel=11 gives 0111.
- Mid-stream reset: rst=1 for one cycle during the sweep -> y=0 for that cycle, then correct results resume the next edge.
- Valid feature (GATE_MUX_VALID_EN): in_valid=0 while a, b, sel change -> y and out_valid hold; in_valid=1 with a=1, b=0, sel=10 -> next cycle y=1, out_valid=1.
